// File: rtl/flo_pkg.sv
// rtl/flo_pkg.sv - shared types and instruction field layout for the flobuffer dispatcher
package flo_pkg;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_WR        = 2'b01,
    OP_WR_DIRECT = 2'b10,
    OP_FINISH    = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_STALL
  } state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 30;
  localparam int IDX_MSB = 29;
  localparam int IDX_LSB = 25;
  localparam int RSV_MSB = 24;
  localparam int RSV_LSB = 23;
  localparam int DLY_MSB = 22;
  localparam int DLY_LSB = 16;
  localparam int DAT_MSB = 15;
  localparam int DAT_LSB = 0;

endpackage

// File: rtl/flo_instr_decode.sv
// rtl/flo_instr_decode.sv - combinational split of a 32-bit instruction word into its fields
module flo_instr_decode
  import flo_pkg::*;
#(
  parameter int num_bufs = 16
) (
  input  logic [31:0] instr_i,
  output logic [1:0]  opcode_o,
  output logic [4:0]  idx_o,
  output logic [6:0]  delay_o,
  output logic [15:0] data_o,
  output logic        idx_invalid_o
);

  logic [1:0] w_unused_rsvd;

  assign opcode_o      = instr_i[OPC_MSB:OPC_LSB];
  assign idx_o         = instr_i[IDX_MSB:IDX_LSB];
  assign delay_o       = instr_i[DLY_MSB:DLY_LSB];
  assign data_o        = instr_i[DAT_MSB:DAT_LSB];
  assign w_unused_rsvd = instr_i[RSV_MSB:RSV_LSB];
  assign idx_invalid_o = (32'(idx_o) >= 32'(num_bufs));

endmodule

// File: rtl/flo_dispatcher.sv
// rtl/flo_dispatcher.sv - fetches instructions from BRAM and issues one-hot writes to a flobuffer bank
module flo_dispatcher
  import flo_pkg::*;
#(
  parameter int num_bufs    = 16,
  parameter int addr_width  = 16,
  parameter int data_width  = 16,
  parameter int delay_width = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic [addr_width-1:0]  mem_addr_o,
  input  logic [31:0]            mem_data_i,
  input  logic [num_bufs-1:0]    full_i,
  output logic [data_width-1:0]  data_o,
  output logic [delay_width-1:0] delay_o,
  output logic [num_bufs-1:0]    valid_o,
  output logic [num_bufs-1:0]    direct_o,
  output logic                   busy_o,
  output logic                   err_o
);

  state_t                 r_state;
  logic [addr_width-1:0]  r_addr;
  logic [data_width-1:0]  r_data;
  logic [delay_width-1:0] r_delay;
  logic [num_bufs-1:0]    r_valid;
  logic [num_bufs-1:0]    r_direct;
  logic                   r_err;
  logic [4:0]             r_hold_idx;
  logic [6:0]             r_hold_delay;
  logic [15:0]            r_hold_data;

  logic [1:0]             w_op_bits;
  opcode_t                w_opcode;
  logic [4:0]             w_idx;
  logic [6:0]             w_delay;
  logic [15:0]            w_data;
  logic                   w_idx_invalid;
  logic [num_bufs-1:0]    w_exec_hot;
  logic [num_bufs-1:0]    w_hold_hot;
  logic                   w_full_exec;
  logic                   w_full_hold;
  logic                   w_advance;
  logic                   w_addr_wrap;
  logic [addr_width-1:0]  w_addr_inc;

  flo_instr_decode #(
    .num_bufs (num_bufs)
  ) u_decode (
    .instr_i       (mem_data_i),
    .opcode_o      (w_op_bits),
    .idx_o         (w_idx),
    .delay_o       (w_delay),
    .data_o        (w_data),
    .idx_invalid_o (w_idx_invalid)
  );

  assign w_opcode    = opcode_t'(w_op_bits);
  assign w_addr_wrap = &r_addr;
  assign w_addr_inc  = r_addr + {{(addr_width-1){1'b0}}, 1'b1};

  // Index decode by loop so an out-of-range idx simply selects nothing.
  always_comb begin
    w_exec_hot  = '0;
    w_hold_hot  = '0;
    w_full_exec = 1'b0;
    w_full_hold = 1'b0;
    for (int i = 0; i < num_bufs; i++) begin
      if (w_idx == 5'(i)) begin
        w_exec_hot[i] = 1'b1;
        w_full_exec   = full_i[i];
      end
      if (r_hold_idx == 5'(i)) begin
        w_hold_hot[i] = 1'b1;
        w_full_hold   = full_i[i];
      end
    end
  end

  always_comb begin
    w_advance = 1'b0;
    if (!stop_i) begin
      if (r_state == ST_EXEC)
        w_advance = (w_opcode != OP_FINISH) &&
                    !(w_opcode == OP_WR && !w_idx_invalid && w_full_exec);
      else if (r_state == ST_STALL)
        w_advance = !w_full_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_data       <= '0;
      r_delay      <= '0;
      r_valid      <= '0;
      r_direct     <= '0;
      r_err        <= 1'b0;
      r_hold_idx   <= '0;
      r_hold_delay <= '0;
      r_hold_data  <= '0;
    end else begin
      r_valid  <= '0;
      r_direct <= '0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_READ;
            r_addr  <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_READ: r_state <= stop_i ? ST_IDLE : ST_EXEC;
        ST_EXEC: begin
          if (stop_i || w_opcode == OP_FINISH) begin
            r_state <= ST_IDLE;
          end else if (w_opcode != OP_NOP && w_idx_invalid) begin
            r_err <= 1'b1;
          end else if (w_opcode == OP_WR_DIRECT) begin
            r_direct <= w_exec_hot;
            r_data   <= w_data;
            r_delay  <= '0;
          end else if (w_opcode == OP_WR) begin
            if (w_full_exec) begin
              r_state      <= ST_STALL;
              r_hold_idx   <= w_idx;
              r_hold_delay <= w_delay;
              r_hold_data  <= w_data;
            end else begin
              r_valid <= w_exec_hot;
              r_data  <= w_data;
              r_delay <= w_delay;
            end
          end
        end
        ST_STALL: begin
          if (stop_i) begin
            r_state <= ST_IDLE;
          end else if (!w_full_hold) begin
            r_valid <= w_hold_hot;
            r_data  <= r_hold_data;
            r_delay <= r_hold_delay;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Every retired instruction except FINISH moves to the next word.
      if (w_advance) begin
        r_state <= ST_READ;
        r_addr  <= w_addr_inc;
        if (w_addr_wrap) r_err <= 1'b1;
      end
    end
  end

  assign mem_addr_o = r_addr;
  assign data_o     = r_data;
  assign delay_o    = r_delay;
  assign valid_o    = r_valid;
  assign direct_o   = r_direct;
  assign busy_o     = (r_state != ST_IDLE);
  assign err_o      = r_err;

endmodule

// File: doc/flo_dispatcher.md
Name: flo_dispatcher

Overview:
Instruction-driven writer feeding an array of flobuffer instances. It fetches 32-bit instruction words from a synchronous BRAM and decodes each into a target buffer index, a delay and a data word. It then issues one buffered (valid) or direct write to the addressed flobuffer, stalling on that buffer's full flag. It is the producer side of the flobuffer data_i/delay_i/valid_i/direct_i/full_o interface and sits between the sequence memory and the flobuffer bank.

Parameters:
num_bufs, 16, number of attached flobuffers (1..32)
addr_width, 16, instruction memory address width
data_width, 16, flobuffer data word width (fixed 16 by instruction format)
delay_width, 7, flobuffer delay width (fixed 7 by instruction format)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_i  in  1  begin execution at address 0 (accepted only in IDLE)
stop_i  in  1  abort execution, return to IDLE
mem_addr_o  out  addr_width  BRAM read address; BRAM read latency is 1 cycle
mem_data_i  in  32  BRAM read data
full_i  in  num_bufs  full_o of each flobuffer
data_o  out  16  data broadcast to all flobuffer data_i
delay_o  out  7  delay broadcast to all flobuffer delay_i
valid_o  out  num_bufs  one-hot buffered-write strobe
direct_o  out  num_bufs  one-hot direct-write strobe
busy_o  out  1  high in any state other than IDLE
err_o  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, on `rst`.
- Reset values: state IDLE, mem_addr_o 0, data_o 0, delay_o 0, valid_o 0, direct_o 0, busy_o 0, err_o 0. Reset mid-execution aborts immediately and issues no strobe.
- Instruction format:
  - [31:30] opcode: 00 NOP, 01 buffered write, 10 direct write, 11 FINISH.
  - [29:25] buffer index.
  - [24:23] reserved, ignored.
  - [22:16] delay.
  - [15:0] data.
- State READ:
  - mem_addr_o holds the current address; the next state is always EXEC.
- State EXEC (mem_data_i valid):
  - NOP: addr+1, then READ.
  - Buffered write, full_i[idx] low: register data_o, delay_o and valid_o[idx]=1 for exactly the next cycle; addr+1; then READ.
  - Buffered write, full_i[idx] high: go to STALL with the word held in an internal register.
  - Direct write: ignores full_i. Register data_o and direct_o[idx]=1 for one cycle; delay_o=0; addr+1; then READ.
  - FINISH: then IDLE, address unchanged.
  - idx >= num_bufs with a write opcode: err_o set, no strobe, addr+1, then READ.
- State STALL:
  - Re-sample full_i[idx] every cycle.
  - When it goes low, issue the held write in the following cycle (same timing as EXEC), addr+1, then READ.
- State IDLE:
  - Entered after FINISH, stop_i or rst.
  - start_i in IDLE clears err_o, sets mem_addr_o=0 and enters READ.
- Throughput: at most one instruction per 2 cycles. Because of this, a strobe issued at cycle t is visible in flobuffer full_o by the next EXEC sample.
- Strobes: valid_o and direct_o are never both non-zero, are at most one-hot, and are always one cycle wide. data_o and delay_o hold their last value when no strobe is active.
- stop_i: in any non-IDLE state, next state is IDLE. stop_i has priority over an issue decided in the same cycle (that strobe is suppressed). A strobe already registered in the previous cycle still completes.
- start_i outside IDLE is ignored. If start_i and stop_i are asserted in the same cycle while in IDLE, start_i wins.
- Address wrap: incrementing past 2^addr_width-1 wraps to 0 and sets err_o. Execution continues.
- err_o: sticky until start_i in IDLE or rst.

Decomposition:
- Shared package flo_pkg:
  - opcode enum (NOP/WR/WR_DIRECT/FINISH).
  - Instruction field bit-position constants.
  - FSM state enum (IDLE/READ/EXEC/STALL).
- One natural sub-module: flo_instr_decode. It is purely combinational: 32-bit word in, opcode/idx/delay/data/idx_invalid out. The FSM and output registers stay in flo_dispatcher.

Test Plan:
1. Single write: memory {WR idx3 delay0 data 0x0011, FINISH}, start_i pulse -> valid_o=0x0008 for one cycle, data_o=0x0011 at cycle 3 after start; busy_o falls 2 cycles later; err_o=0.
2. Mixed stream: WR idx0 d5 0xAAAA, NOP, WR_DIRECT idx1 0x1234, FINISH -> strobe valid_o=0x0001 with delay_o=5, then a 4-cycle gap, then direct_o=0x0002 with delay_o=0; no valid_o during the NOP.
3. Stall: full_i[2] held high for 10 cycles while WR idx2 0x5555 is in EXEC -> no strobe while full; valid_o[2] fires exactly 1 cycle after full_i[2] falls; next address is fetched only afterwards.
4. Direct under full: full_i[4]=1, WR_DIRECT idx4 0x0777 -> direct_o[4] fires with no stall.
5. Errors: WR idx20 (num_bufs=16) -> err_o=1, no strobe, execution continues to FINISH; a subsequent start_i clears err_o. addr_width=4 with no FINISH in 16 words -> wrap to 0 sets err_o.
6. Abort: stop_i during STALL, and rst during EXEC -> IDLE next cycle, no strobe, busy_o=0, mem_addr_o retained after stop and 0 after rst; a new start_i re-executes from address 0.
